// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM soft-start/soft-stop sequencer.
// No logic; constants only.
// Not applicable (package).
package pwm_pkg;

    localparam int RATIO_W = 8;

    // State encodings shared by the FSM and anything that decodes it.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] REQ   = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_RUN   = RUN,
        S_REQ   = REQ,
        S_FAULT = FAULT
    } state_t;

endpackage

// File: rtl/ramp_step_calc.sv
// Next PWM ratio: moves current toward target by at most one step, saturating.
// Purely combinational, zero latency.
// No handshake; the caller samples the result when it needs it.
module ramp_step_calc
    import pwm_pkg::*;
(
    input  logic [RATIO_W-1:0] i_cur,
    input  logic [RATIO_W-1:0] i_tgt,
    input  logic [RATIO_W-1:0] i_step,
    output logic [RATIO_W-1:0] o_next
);

    // One extra bit so differences and sums never wrap past 0 or full scale.
    logic [RATIO_W:0] w_cur;
    logic [RATIO_W:0] w_tgt;
    logic [RATIO_W:0] w_step;
    logic [RATIO_W:0] w_diff;
    logic [RATIO_W:0] w_sum;
    logic [RATIO_W:0] w_sub;
    logic             w_up;

    assign w_cur  = {1'b0, i_cur};
    assign w_tgt  = {1'b0, i_tgt};
    assign w_step = {1'b0, i_step};
    assign w_up   = (w_tgt > w_cur);
    assign w_diff = w_up ? (w_tgt - w_cur) : (w_cur - w_tgt);
    assign w_sum  = w_cur + w_step;
    assign w_sub  = w_cur - w_step;

    // Jump to target when step is 0 or target is within one step, else step toward it.
    always_comb begin
        o_next = i_tgt;
        if ((i_step != '0) && (w_diff > w_step)) begin
            if (w_up) begin
                o_next = w_sum[RATIO_W] ? {RATIO_W{1'b1}} : w_sum[RATIO_W-1:0];
            end else begin
                o_next = w_sub[RATIO_W] ? '0 : w_sub[RATIO_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer feeding the PWM generator one ratio step per tick.
// Ratio/update registered: request appears the cycle after the tick; ack consumed in one cycle.
// Holds pwm_update/pwm_ratio until pwm_done; faults if no ack within ACK_TIMEOUT cycles.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int ACK_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               ramp_enable,
    input  logic [RATIO_W-1:0] target_ratio,
    input  logic [RATIO_W-1:0] ramp_step,
    input  logic               estop,
    input  logic               pwm_done,
    output logic               pwm_enable,
    output logic [RATIO_W-1:0] pwm_ratio,
    output logic               pwm_update,
    output logic [RATIO_W-1:0] current_ratio,
    output logic               ramp_busy,
    output logic               fault
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ACK_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic [CNT_W-1:0]   r_to_cnt;
    logic               r_pwm_enable;
    logic [RATIO_W-1:0] r_pwm_ratio;
    logic               r_pwm_update;
    logic [RATIO_W-1:0] r_current_ratio;
    logic               r_fault;

    logic [RATIO_W-1:0] w_tgt;
    logic [RATIO_W-1:0] w_next_ratio;
    logic               w_tick;
    logic               w_to_hit;
    logic               w_load_req;
    logic               w_ack;
    logic               w_active;

    // Disabling the ramp means "walk down to zero".
    assign w_tgt    = ramp_enable ? target_ratio : '0;
    assign w_active = (r_state == S_RUN) || (r_state == S_REQ);
    // Ticks that land while a request is outstanding are simply lost.
    assign w_tick   = (r_state == S_RUN) && (r_tick_cnt == TICK_LAST);
    assign w_to_hit = (r_to_cnt == TO_LAST);

    ramp_step_calc u_step (
        .i_cur  (r_current_ratio),
        .i_tgt  (w_tgt),
        .i_step (ramp_step),
        .o_next (w_next_ratio)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; estop wins everywhere except FAULT, done wins over timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_load_req  = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ramp_enable && !estop) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (estop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    if (r_current_ratio != w_tgt) begin
                        w_load_req  = 1'b1;
                        w_state_nxt = S_REQ;
                    end else if (!ramp_enable) begin
                        // current == tgt == 0 here: ramp-down finished.
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_REQ: begin
                if (estop) begin
                    w_state_nxt = S_IDLE;
                end else if (pwm_done) begin
                    w_ack       = 1'b1;
                    w_state_nxt = S_RUN;
                end else if (w_to_hit) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_FAULT: begin
                if (!ramp_enable) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tick divider runs through RUN and REQ, parked at 0 otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (!w_active) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Ack timeout counts only while a request stays outstanding.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_REQ) && (w_state_nxt == S_REQ)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Generator-facing outputs, all registered off the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_enable    <= 1'b0;
            r_pwm_ratio     <= '0;
            r_pwm_update    <= 1'b0;
            r_current_ratio <= '0;
            r_fault         <= 1'b0;
        end else begin
            r_pwm_enable <= (w_state_nxt == S_RUN) || (w_state_nxt == S_REQ);
            r_pwm_update <= (w_state_nxt == S_REQ);
            r_fault      <= (w_state_nxt == S_FAULT);
            if (w_load_req) begin
                r_pwm_ratio <= w_next_ratio;
            end
            if (w_ack) begin
                r_current_ratio <= r_pwm_ratio;
            end else if ((w_state_nxt == S_FAULT) || (estop && (r_state != S_FAULT))) begin
                r_current_ratio <= '0;
            end
        end
    end

    assign pwm_enable    = r_pwm_enable;
    assign pwm_ratio     = r_pwm_ratio;
    assign pwm_update    = r_pwm_update;
    assign current_ratio = r_current_ratio;
    assign fault         = r_fault;
    assign ramp_busy     = (r_state == S_REQ) ||
                           ((r_state == S_RUN) && (r_current_ratio != w_tgt));

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: table of ramp scenarios checked through an update scoreboard,
// plus hand-written sequences for in-flight target change, estop, ack timeout and reset.
// Auto-acker answers each update 5 cycles after it rises unless manual mode is selected.
module tb_pwm_ramp_ctrl;

    localparam int TICK_DIV    = 16;
    localparam int ACK_TIMEOUT = 64;

    logic       clock;
    logic       reset_n;
    logic       ramp_enable;
    logic [7:0] target_ratio;
    logic [7:0] ramp_step;
    logic       estop;
    logic       pwm_done;
    logic       pwm_enable;
    logic [7:0] pwm_ratio;
    logic       pwm_update;
    logic [7:0] current_ratio;
    logic       ramp_busy;
    logic       fault;

    logic       auto_done;
    logic       man_done;
    bit         ack_en;
    bit         pending;
    int         ack_cnt;
    logic [7:0] held_ratio;
    logic [7:0] exp_q[$];

    int n_checks;
    int n_fail;

    assign pwm_done = auto_done | man_done;

    pwm_ramp_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (16)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ramp_enable   (ramp_enable),
        .target_ratio  (target_ratio),
        .ramp_step     (ramp_step),
        .estop         (estop),
        .pwm_done      (pwm_done),
        .pwm_enable    (pwm_enable),
        .pwm_ratio     (pwm_ratio),
        .pwm_update    (pwm_update),
        .current_ratio (current_ratio),
        .ramp_busy     (ramp_busy),
        .fault         (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic            en;
        logic [7:0]      step;
        logic [7:0]      tgt;
        logic [3:0]      n;
        logic [3:0][7:0] exp;
        logic [7:0]      fin;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic en, input logic [7:0] step, input logic [7:0] tgt,
                                input logic [3:0] n, input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] fin);
        vec_t v;
        v.en     = en;
        v.step   = step;
        v.tgt    = tgt;
        v.n      = n;
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        v.fin    = fin;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic bound_expired(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Wait until all expected updates are consumed and the ramp has settled.
    task automatic settle(input bit need_off, input string nm);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            cyc();
            if (exp_q.size() == 0 && !pending && !ramp_busy && (!need_off || !pwm_enable)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_expired(nm);
        exp_q.delete();
    endtask

    task automatic wait_upd(input string nm);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (pwm_update) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_expired(nm);
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
    endtask

    // Auto-acker: pops the scoreboard on each new update, acks 5 cycles after it rose.
    initial begin
        logic [7:0] e;
        auto_done = 1'b0;
        pending   = 1'b0;
        ack_cnt   = 0;
        forever begin
            cyc();
            if (!reset_n || !ack_en) begin
                auto_done = 1'b0;
                pending   = 1'b0;
            end else if (pending) begin
                if (auto_done) begin
                    auto_done = 1'b0;
                    pending   = 1'b0;
                end else begin
                    ack_cnt++;
                    if (ack_cnt == 4) begin
                        chk("ratio_stable", 32'(pwm_ratio), 32'(held_ratio));
                        auto_done = 1'b1;
                    end
                end
            end else if (pwm_update) begin
                pending    = 1'b1;
                ack_cnt    = 0;
                held_ratio = pwm_ratio;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: update with ratio %0d, none expected", pwm_ratio);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_ratio", 32'(pwm_ratio), 32'(e));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        ramp_enable  = 1'b0;
        target_ratio = 8'd0;
        ramp_step    = 8'd0;
        estop        = 1'b0;
        man_done     = 1'b0;
        ack_en       = 1'b1;

        vecs[0] = mk(1'b1, 8'd10,  8'd35,  4'd4, 8'd10,  8'd20,  8'd30, 8'd35, 8'd35);
        vecs[1] = mk(1'b0, 8'd10,  8'd35,  4'd4, 8'd25,  8'd15,  8'd5,  8'd0,  8'd0);
        vecs[2] = mk(1'b1, 8'd0,   8'd200, 4'd1, 8'd200, 8'd0,   8'd0,  8'd0,  8'd200);
        vecs[3] = mk(1'b1, 8'd100, 8'd20,  4'd2, 8'd100, 8'd20,  8'd0,  8'd0,  8'd20);
        vecs[4] = mk(1'b1, 8'd200, 8'd255, 4'd2, 8'd220, 8'd255, 8'd0,  8'd0,  8'd255);
        vecs[5] = mk(1'b0, 8'd255, 8'd255, 4'd1, 8'd0,   8'd0,   8'd0,  8'd0,  8'd0);

        repeat (3) cyc();
        chk("rst_enable",  32'(pwm_enable),    0);
        chk("rst_ratio",   32'(pwm_ratio),     0);
        chk("rst_update",  32'(pwm_update),    0);
        chk("rst_current", 32'(current_ratio), 0);
        chk("rst_busy",    32'(ramp_busy),     0);
        chk("rst_fault",   32'(fault),         0);
        reset_n = 1'b1;
        cyc();

        // Table-driven ramps through the scoreboard.
        for (int i = 0; i < 6; i++) begin
            ramp_enable  = vecs[i].en;
            ramp_step    = vecs[i].step;
            target_ratio = vecs[i].tgt;
            for (int k = 0; k < int'(vecs[i].n); k++) exp_q.push_back(vecs[i].exp[k]);
            settle(!vecs[i].en, $sformatf("v%0d_settle", i));
            chk($sformatf("v%0d_current", i), 32'(current_ratio), 32'(vecs[i].fin));
            chk($sformatf("v%0d_enable", i),  32'(pwm_enable),    32'(vecs[i].en));
            chk($sformatf("v%0d_update", i),  32'(pwm_update),    0);
        end

        // Target change while a request is in flight.
        ramp_enable  = 1'b1;
        ramp_step    = 8'd0;
        target_ratio = 8'd50;
        exp_q.push_back(8'd50);
        settle(1'b0, "tc_prep");
        chk("tc_prep_current", 32'(current_ratio), 50);
        ack_en = 1'b0;
        cyc();
        ramp_step    = 8'd10;
        target_ratio = 8'd100;
        wait_upd("tc_upd1");
        chk("tc_inflight_ratio", 32'(pwm_ratio), 60);
        target_ratio = 8'd50;
        repeat (3) cyc();
        chk("tc_inflight_hold", 32'(pwm_ratio), 60);
        chk("tc_inflight_busy", 32'(ramp_busy), 1);
        pulse_done();
        chk("tc_acked_current", 32'(current_ratio), 60);
        chk("tc_acked_update",  32'(pwm_update),    0);
        wait_upd("tc_upd2");
        chk("tc_next_ratio", 32'(pwm_ratio), 50);
        pulse_done();
        chk("tc_final_current", 32'(current_ratio), 50);
        chk("tc_final_busy",    32'(ramp_busy),     0);

        // Emergency stop mid-request, then a late ack.
        ramp_step    = 8'd0;
        target_ratio = 8'd90;
        wait_upd("es_upd");
        chk("es_req_ratio", 32'(pwm_ratio), 90);
        estop = 1'b1;
        cyc();
        chk("es_update",  32'(pwm_update),    0);
        chk("es_enable",  32'(pwm_enable),    0);
        chk("es_current", 32'(current_ratio), 0);
        pulse_done();
        chk("es_late_current", 32'(current_ratio), 0);
        chk("es_late_update",  32'(pwm_update),    0);
        repeat (20) cyc();
        chk("es_hold_enable", 32'(pwm_enable), 0);
        chk("es_hold_busy",   32'(ramp_busy),  0);
        estop = 1'b0;

        // Ack timeout: generator never answers.
        wait_upd("to_upd");
        chk("to_req_ratio", 32'(pwm_ratio), 90);
        repeat (ACK_TIMEOUT - 1) cyc();
        chk("to_before_fault",  32'(fault),      0);
        chk("to_before_update", 32'(pwm_update), 1);
        cyc();
        chk("to_fault",   32'(fault),         1);
        chk("to_enable",  32'(pwm_enable),    0);
        chk("to_update",  32'(pwm_update),    0);
        chk("to_current", 32'(current_ratio), 0);
        pulse_done();
        repeat (10) cyc();
        chk("to_fault_sticky", 32'(fault), 1);
        ramp_enable = 1'b0;
        cyc();
        chk("to_fault_clear",   32'(fault),      0);
        chk("to_enable_after",  32'(pwm_enable), 0);

        // Reset mid-operation: everything drops without a ramp-down.
        ack_en       = 1'b1;
        ramp_enable  = 1'b1;
        ramp_step    = 8'd0;
        target_ratio = 8'd123;
        exp_q.push_back(8'd123);
        settle(1'b0, "rs_prep");
        chk("rs_prep_current", 32'(current_ratio), 123);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_enable",  32'(pwm_enable),    0);
        chk("rs_ratio",   32'(pwm_ratio),     0);
        chk("rs_update",  32'(pwm_update),    0);
        chk("rs_current", 32'(current_ratio), 0);
        chk("rs_busy",    32'(ramp_busy),     0);
        chk("rs_fault",   32'(fault),         0);
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Soft-start/soft-stop sequencer directly upstream of the motor PWM generator.
- Takes a software target duty (0-255) and a step size, and walks the PWM ratio toward the target one step per ramp tick.
- Each step is delivered through the generator's pwm_update/pwm_done handshake.
- Owns the generator's enable: ramps to 0 before releasing it, supports emergency stop, and flags a fault if the generator never acknowledges.

Parameters:
- TICK_DIV, 1000: clock cycles between ramp steps, minimum 2.
- ACK_TIMEOUT, 1024: cycles to wait for pwm_done after raising pwm_update before faulting. Must exceed one 256-cycle PWM frame plus margin.
- CNT_W, 16: width of tick and timeout counters. Must hold max(TICK_DIV, ACK_TIMEOUT).

Ports:
- clock  input  1  main clock
- reset_n  input  1  asynchronous active-low reset
- ramp_enable  input  1  level; 1 = run toward target_ratio, 0 = ramp down to 0 then stop
- target_ratio  input  8  requested duty (out of 255), sampled each tick
- ramp_step  input  8  max ratio change per tick; 0 = jump straight to target
- estop  input  1  level; emergency stop, overrides everything
- pwm_done  input  1  one-cycle ack from PWM generator
- pwm_enable  output  1  enable to PWM generator
- pwm_ratio  output  8  ratio presented to PWM generator, stable while pwm_update=1
- pwm_update  output  1  update request, held until pwm_done
- current_ratio  output  8  last ratio acknowledged by generator
- ramp_busy  output  1  1 while current_ratio != effective target or a request is pending
- fault  output  1  sticky ack-timeout flag

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Tick and timeout counters 0.
- Effective target (tgt):
  - target_ratio when ramp_enable=1, else 0.
- States:
  - IDLE:
    - pwm_enable=0.
    - ramp_enable=1 and estop=0 -> RUN; pwm_enable=1 from the next cycle; tick counter cleared.
  - RUN:
    - Tick counter increments every cycle and wraps at TICK_DIV-1; the wrap cycle is a tick.
    - On a tick with current_ratio != tgt, compute next:
      - If ramp_step=0 or |tgt-current| <= ramp_step, next = tgt.
      - Otherwise next = current ± ramp_step.
      - Arithmetic is 9-bit unsigned, so there is no wrap past 0 or 255.
    - Drive pwm_ratio=next and pwm_update=1, then go to REQ.
    - On a tick with current_ratio = tgt = 0 and ramp_enable=0 -> IDLE; pwm_enable drops that cycle.
    - Otherwise stay in RUN.
  - REQ:
    - pwm_update and pwm_ratio held constant; timeout counter increments.
    - pwm_done=1 -> pwm_update=0, current_ratio<=pwm_ratio, timeout cleared, back to RUN.
    - The tick counter keeps running in REQ; a tick occurring in REQ is dropped, not queued.
    - Timeout counter reaches ACK_TIMEOUT-1 without pwm_done -> FAULT.
  - FAULT:
    - fault=1, pwm_enable=0, pwm_update=0, current_ratio=0.
    - Leaves to IDLE only after ramp_enable=0 for at least 1 cycle; fault clears on that exit.
- estop=1 in any state except FAULT:
  - Same cycle next-state is IDLE.
  - pwm_enable=0, pwm_update=0, current_ratio=0 on the next edge.
  - Stays IDLE while estop=1, even if ramp_enable=1.
- pwm_done while not in REQ is ignored.
- pwm_done and the timeout limit in the same cycle: done wins.
- target_ratio changes mid-request do not alter the pwm_ratio in flight; the new value is used at the next tick.
- ramp_busy = (state==REQ) | (state==RUN & current_ratio!=tgt).
- Reset asserted mid-operation forces all outputs to 0 immediately, with no ramp-down.

Decomposition:
- Shared package (pwm_pkg):
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, REQ=2'd2, FAULT=2'd3.
  - Ratio width constant RATIO_W=8.
- One natural sub-module, ramp_step_calc: combinational next-ratio saturation from current, tgt and step.
- The tick counter stays inline.

Test Plan:
- Ramp up:
  - Stimulus: TICK_DIV=16, step=10, target=35, ramp_enable=1, bench acks pwm_done 5 cycles after each update.
  - Required: pwm_ratio sequence 10, 20, 30, 35; then ramp_busy=0 and current_ratio=35.
- Ramp down on disable:
  - Stimulus: from current 35, ramp_enable=0.
  - Required: ratios 25, 15, 5, 0; pwm_enable drops on the first tick after current=0 is acked; state IDLE.
- Jump mode:
  - Stimulus: step=0, target=200.
  - Required: a single update with pwm_ratio=200.
- Ack timeout:
  - Stimulus: bench never asserts pwm_done, ACK_TIMEOUT=64.
  - Required: fault=1 and pwm_enable=0 64 cycles after pwm_update rose; fault stays until ramp_enable=0, then clears.
- Estop mid-request:
  - Stimulus: estop=1 while pwm_update=1.
  - Required: next cycle pwm_update=0, pwm_enable=0, current_ratio=0; a late pwm_done is ignored.
- Target change in flight:
  - Stimulus: target moves 100 -> 50 while REQ holds pwm_ratio=60 (current 50, step 10).
  - Required: 60 acked unchanged; next update is 50.
